// File: rtl/nspi_rx_if.sv
// ============================================================================
// nspi_rx_if : serial input lanes and word handshake of the nspi_rx receiver
// Rev 1.0
// ============================================================================
`default_nettype none

interface nspi_rx_if #(
   parameter int CHANNEL_NUMBER = 2,
   parameter int SPI_SIZE       = 8
);
   logic                      spi_clk;
   logic [CHANNEL_NUMBER-1:0] spi_mosi;
   logic [SPI_SIZE-1:0]       data_out [CHANNEL_NUMBER];
   logic                      data_valid;
   logic                      data_ready;
   logic                      overrun;
   logic                      busy;

   modport master (
      output spi_clk, spi_mosi, data_ready,
      input  data_out, data_valid, overrun, busy
   );

   modport slave (
      input  spi_clk, spi_mosi, data_ready,
      output data_out, data_valid, overrun, busy
   );
endinterface

`default_nettype wire

// File: rtl/nspi_rx.sv
// ============================================================================
// nspi_rx : multi-lane SPI mode-0 receiver, words presented via valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

module nspi_rx #(
   parameter int CHANNEL_NUMBER = 2,
   parameter int SPI_SIZE       = 8,
   parameter int MSB_FIRST      = 1,
   parameter int TIMEOUT        = 64
) (
   input  logic     clk,
   input  logic     rst,
   nspi_rx_if.slave bus
);
   localparam int CNT_W = $clog2(SPI_SIZE + 1);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [1:0]                sclk_sync_q;
   logic                      sclk_prev_q;
   logic [CHANNEL_NUMBER-1:0] mosi_meta_q, mosi_sync_q;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [TO_W-1:0]           to_q, to_d;
   logic                      valid_q, valid_d;
   logic                      ovr_q, ovr_d;
   logic                      w_edge;
   logic                      w_done;

   // MOSI gets the same two-stage depth as spi_clk so data and edge stay aligned
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         mosi_meta_q <= '0;
         mosi_sync_q <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], bus.spi_clk};
         sclk_prev_q <= sclk_sync_q[1];
         mosi_meta_q <= bus.spi_mosi;
         mosi_sync_q <= mosi_meta_q;
      end
   end

   assign w_edge = sclk_sync_q[1] & ~sclk_prev_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      w_done  = 1'b0;
      case (state_q)
         S_IDLE: begin
            to_d = '0;
            if (w_edge) begin
               cnt_d   = CNT_W'(1);
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_edge) begin
               to_d = '0;
               if (cnt_q == CNT_W'(SPI_SIZE - 1)) begin
                  w_done  = 1'b1;
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (to_q == TO_W'(TIMEOUT - 1)) begin
               // stalled frame: drop the partial word silently
               cnt_d   = '0;
               to_d    = '0;
               state_d = S_IDLE;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            to_d    = '0;
         end
      endcase
   end

   assign valid_d = w_done | (valid_q & ~bus.data_ready);
   assign ovr_d   = w_done & valid_q & ~bus.data_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         to_q    <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   for (genvar c = 0; c < CHANNEL_NUMBER; c++) begin : g_lane
      logic [SPI_SIZE-1:0] shift_q, shift_d;
      logic [SPI_SIZE-1:0] data_q;

      if (MSB_FIRST != 0) begin : g_msb
         assign shift_d = {shift_q[SPI_SIZE-2:0], mosi_sync_q[c]};
      end else begin : g_lsb
         assign shift_d = {mosi_sync_q[c], shift_q[SPI_SIZE-1:1]};
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            shift_q <= '0;
            data_q  <= '0;
         end else begin
            if (w_edge) shift_q <= shift_d;
            if (w_done) data_q  <= shift_d;
         end
      end

      assign bus.data_out[c] = data_q;
   end

   assign bus.data_valid = valid_q;
   assign bus.overrun    = ovr_q;
   assign bus.busy       = (state_q == S_SHIFT);
endmodule

`default_nettype wire

// File: tb/tb_nspi_rx.sv
// ============================================================================
// tb_nspi_rx : randomized bench for nspi_rx, MSB-first and LSB-first instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_nspi_rx;
   localparam int CH = 2;
   localparam int SZ = 8;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          spi_clk = 1'b0;
   logic [CH-1:0] mosi = '0;
   logic          ready = 1'b0;
   bit            rand_ready = 1'b0;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   nspi_rx_if #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SZ)) if_m ();
   nspi_rx_if #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SZ)) if_l ();

   assign if_m.spi_clk    = spi_clk;
   assign if_m.spi_mosi   = mosi;
   assign if_m.data_ready = ready;
   assign if_l.spi_clk    = spi_clk;
   assign if_l.spi_mosi   = mosi;
   assign if_l.data_ready = ready;

   nspi_rx #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .MSB_FIRST(1), .TIMEOUT(TO)) dut_m (
      .clk(clk), .rst(rst), .bus(if_m));
   nspi_rx #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .MSB_FIRST(0), .TIMEOUT(TO)) dut_l (
      .clk(clk), .rst(rst), .bus(if_l));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Inputs reach the edge detector two clocks after capture; effects are
   // visible one clock later, so an input pair captured at posedge q-2/q-3
   // decides what the outputs become at posedge q.
   logic          h_clk [4];
   logic [CH-1:0] h_mosi[4];
   logic [CH-1:0] bq[$];
   int            idle;
   logic [SZ-1:0] exp_m[CH], exp_l[CH];
   bit            exp_v, exp_o, exp_b;

   always @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin h_clk[k] = 1'b0; h_mosi[k] = '0; end
         bq.delete();
         idle = 0;
         for (int c = 0; c < CH; c++) begin exp_m[c] = '0; exp_l[c] = '0; end
         exp_v = 0; exp_o = 0; exp_b = 0;
      end else begin
         bit done;
         for (int k = 3; k > 0; k--) begin h_clk[k] = h_clk[k-1]; h_mosi[k] = h_mosi[k-1]; end
         h_clk[0]  = spi_clk;
         h_mosi[0] = mosi;
         done  = 0;
         exp_o = 0;
         if (h_clk[2] && !h_clk[3]) begin
            bq.push_back(h_mosi[2]);
            idle = 0;
            if (bq.size() == SZ) begin
               done = 1;
               for (int c = 0; c < CH; c++)
                  for (int i = 0; i < SZ; i++) begin
                     exp_m[c][SZ-1-i] = bq[i][c];
                     exp_l[c][i]      = bq[i][c];
                  end
               bq.delete();
            end
         end else if (bq.size() > 0) begin
            idle++;
            if (idle == TO) begin bq.delete(); idle = 0; end
         end
         if (done) begin
            exp_o = exp_v && !ready;
            exp_v = 1;
         end else if (ready) begin
            exp_v = 0;
         end
         exp_b = bq.size() > 0;
      end
   end

   // ---------------- per-cycle compare and observers ----------------
   int            vcount, ocount;
   logic [SZ-1:0] cap_m[CH], cap_l[CH];

   always @(negedge clk) begin
      if (rst) begin
         chk("valid_m", 32'(if_m.data_valid), 32'(exp_v));
         chk("valid_l", 32'(if_l.data_valid), 32'(exp_v));
         chk("overrun_m", 32'(if_m.overrun), 32'(exp_o));
         chk("overrun_l", 32'(if_l.overrun), 32'(exp_o));
         chk("busy_m", 32'(if_m.busy), 32'(exp_b));
         chk("busy_l", 32'(if_l.busy), 32'(exp_b));
         for (int c = 0; c < CH; c++) begin
            chk($sformatf("data_m[%0d]", c), 32'(if_m.data_out[c]), 32'(exp_m[c]));
            chk($sformatf("data_l[%0d]", c), 32'(if_l.data_out[c]), 32'(exp_l[c]));
         end
         if (if_m.data_valid) begin
            vcount++;
            for (int c = 0; c < CH; c++) begin cap_m[c] = if_m.data_out[c]; cap_l[c] = if_l.data_out[c]; end
         end
         if (if_m.overrun) ocount++;
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1 ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // bits go out in order w[SZ-1] .. w[SZ-nb]
   task automatic send_bits(input logic [SZ-1:0] w0, input logic [SZ-1:0] w1,
                            input int nb, input int half);
      for (int i = 0; i < nb; i++) begin
         mosi[0] = w0[SZ-1-i];
         mosi[1] = w1[SZ-1-i];
         tick(half);
         spi_clk = 1'b1;
         tick(half);
         spi_clk = 1'b0;
      end
   endtask

   task automatic expect_caps(input string nm, input logic [SZ-1:0] m0, input logic [SZ-1:0] m1,
                              input logic [SZ-1:0] l0, input logic [SZ-1:0] l1);
      chk({nm, "_m0"}, 32'(cap_m[0]), 32'(m0));
      chk({nm, "_m1"}, 32'(cap_m[1]), 32'(m1));
      chk({nm, "_l0"}, 32'(cap_l[0]), 32'(l0));
      chk({nm, "_l1"}, 32'(cap_l[1]), 32'(l1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [SZ-1:0] a, b, ra, rb;
      tick(3);
      chk("rst_valid", 32'(if_m.data_valid), 32'd0);
      chk("rst_busy", 32'(if_m.busy), 32'd0);
      chk("rst_overrun", 32'(if_m.overrun), 32'd0);
      chk("rst_data0", 32'(if_m.data_out[0]), 32'd0);
      chk("rst_data1", 32'(if_l.data_out[1]), 32'd0);
      rst = 1'b1;
      tick(2);

      // basic, spi_clk period 8
      ready = 1'b1; vcount = 0;
      send_bits(8'h01, 8'h00, SZ, 4);
      tick(6);
      chk("basic_vcycles", 32'(vcount), 32'd1);
      chk("basic_overruns", 32'(ocount), 32'd0);
      expect_caps("basic", 8'h01, 8'h00, 8'h80, 8'h00);
      chk("model_pin_basic", 32'(exp_m[0]), 32'h01);

      // bit order: serial 1,0,...,0 on ch0; 0xA5 pattern on ch1
      send_bits(8'h80, 8'hA5, SZ, 3);
      tick(6);
      expect_caps("order", 8'h80, 8'hA5, 8'h01, 8'hA5);
      send_bits(8'h5A, 8'h0F, SZ, 5);
      tick(6);
      expect_caps("order2", 8'h5A, 8'h0F, 8'h5A, 8'hF0);

      // backpressure / overrun
      ready = 1'b0; ocount = 0;
      send_bits(8'h11, 8'h22, SZ, 4);
      tick(4);
      send_bits(8'h33, 8'h44, SZ, 4);
      tick(6);
      chk("ovr_count", 32'(ocount), 32'd1);
      chk("ovr_valid", 32'(if_m.data_valid), 32'd1);
      chk("ovr_d0", 32'(if_m.data_out[0]), 32'h33);
      chk("ovr_d1", 32'(if_m.data_out[1]), 32'h44);
      ready = 1'b1;
      tick(1);
      chk("ovr_release", 32'(if_m.data_valid), 32'd0);

      // timeout of a partial frame
      vcount = 0;
      send_bits(8'hFF, 8'hFF, 5, 4);
      tick(70);
      chk("to_busy", 32'(if_m.busy), 32'd0);
      chk("to_novalid", 32'(vcount), 32'd0);
      send_bits(8'hC3, 8'h3C, SZ, 4);
      tick(6);
      expect_caps("after_to", 8'hC3, 8'h3C, 8'hC3, 8'h3C);

      // ready asserted in the very cycle the next word loads
      ready = 1'b0; ocount = 0;
      send_bits(8'h12, 8'h34, SZ, 4);
      tick(4);
      send_bits(8'h56, 8'h78, SZ - 1, 4);
      mosi[0] = 1'b0; mosi[1] = 1'b0;
      tick(4);
      spi_clk = 1'b1;
      tick(2);
      ready = 1'b1;
      tick(1);
      chk("sim_valid", 32'(if_m.data_valid), 32'd1);
      chk("sim_d0", 32'(if_m.data_out[0]), 32'h56);
      chk("sim_d1", 32'(if_m.data_out[1]), 32'h78);
      chk("sim_overrun", 32'(ocount), 32'd0);
      tick(2);
      spi_clk = 1'b0;
      tick(6);

      // reset in the middle of a frame with a word pending
      ready = 1'b0;
      send_bits(8'h9A, 8'hBC, SZ, 4);
      tick(4);
      send_bits(8'hE0, 8'hE0, 3, 4);
      rst = 1'b0;
      #2;
      chk("mid_rst_valid", 32'(if_m.data_valid), 32'd0);
      chk("mid_rst_busy", 32'(if_m.busy), 32'd0);
      chk("mid_rst_d0", 32'(if_m.data_out[0]), 32'd0);
      tick(2);
      rst = 1'b1;
      ready = 1'b1;
      tick(2);
      send_bits(8'h7E, 8'h81, SZ, 4);
      tick(6);
      expect_caps("after_rst", 8'h7E, 8'h81, 8'h7E, 8'h81);

      // randomized frames with random backpressure and occasional stalls
      rand_ready = 1'b1;
      for (int f = 0; f < 24; f++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            send_bits(a, b, int'($urandom_range(1, SZ - 1)), int'($urandom_range(3, 6)));
            tick(TO + 4);
         end else begin
            send_bits(a, b, SZ, int'($urandom_range(3, 6)));
         end
         tick(int'($urandom_range(0, 10)));
      end
      rand_ready = 1'b0;
      tick(2);
      ready = 1'b1;
      a = 8'hB4; b = 8'h2D;
      for (int i = 0; i < SZ; i++) begin ra[i] = a[SZ-1-i]; rb[i] = b[SZ-1-i]; end
      send_bits(a, b, SZ, 3);
      tick(6);
      expect_caps("final", a, b, ra, rb);
      chk("model_pin_final", 32'(exp_l[0]), 32'h2D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/nspi_rx.md
Name: nspi_rx

Overview:
Multi-channel SPI receiver, the receive-side counterpart of nspi_tx. Samples one shared spi_clk and CHANNEL_NUMBER parallel MOSI lines, all asynchronous to the system clock. Deserialises one SPI_SIZE-bit word per channel per frame and presents them together with a valid/ready handshake. It is used on the matrix-controller side and in loopback benches against nspi_tx.

Parameters:
CHANNEL_NUMBER, 2, number of parallel MOSI lanes sharing spi_clk
SPI_SIZE, 8, bits per word per channel
MSB_FIRST, 1, 1 = first received bit lands in bit SPI_SIZE-1; 0 = first bit lands in bit 0
TIMEOUT, 64, clk cycles without a synchronised spi_clk rising edge before a partial word is discarded

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (0 = reset)
spi_clk  input  1  serial clock from transmitter, idle low, asynchronous to clk
spi_mosi  input  CHANNEL_NUMBER  serial data lanes, one per channel
data_out  output  [SPI_SIZE-1:0] x CHANNEL_NUMBER (unpacked array)  received words, index = channel
data_valid  output  1  data_out holds an unconsumed word set
data_ready  input  1  consumer accepts data_out when high together with data_valid
overrun  output  1  one-cycle pulse: a word set was lost
busy  output  1  high while a frame is partially received

Behaviour:
- Reset (rst=0, async): all outputs 0, data_out all zeros, synchronisers cleared, FSM=IDLE, bit counter 0, timeout counter 0.
- Synchronisation: spi_clk and every spi_mosi lane pass through 2-FF synchronisers of equal depth, followed by one extra register on synced spi_clk for edge detection. Rising edge detected in cycle N when synced spi_clk=1 and its previous value=0.
- Data is sampled in the same cycle N from the synced MOSI value (SPI mode 0: tx changes data on falling edge). Precondition: spi_clk high and low phases each >= 3 clk periods; behaviour is undefined if this is violated.
- Shift: MSB_FIRST=1 shifts left, inserting at bit 0; MSB_FIRST=0 shifts right, inserting at bit SPI_SIZE-1. This applies per channel, with all channels shifted together.
- FSM IDLE: busy=0. The first detected rising edge samples bit 0, sets the bit count to 1, and moves to SHIFT.
- FSM SHIFT: busy=1. Each detected rising edge samples a bit and increments the count. On the edge that completes SPI_SIZE bits, the shift registers are copied to data_out in cycle N+1, data_valid=1 from N+1, and the FSM returns to IDLE with count 0.
- Timeout: in SHIFT, the counter resets on each detected edge and increments otherwise. When it reaches TIMEOUT, the partial word is dropped, the FSM returns to IDLE, busy=0, data_out is untouched, and no overrun is flagged.
- Handshake: data_valid stays high until a cycle with data_ready=1, then clears next cycle. data_out is stable while data_valid=1, except on overrun.
- Overrun: a word completes while data_valid=1 and data_ready=0. data_out is overwritten with the new word, data_valid stays 1, and overrun=1 for exactly one cycle.
- Simultaneous completion and data_ready=1 with data_valid=1: the old word is consumed, the new word is loaded, data_valid stays 1, and overrun=0.
- data_ready while data_valid=0 is ignored.
- spi_clk falling edges are not used, except that they are implicitly required between rising edges.
- Reset asserted mid-frame: the partial word is discarded immediately, and reception restarts cleanly on the first rising edge after rst releases.

Test Plan:
- Basic: CHANNEL_NUMBER=2, SPI_SIZE=8, MSB_FIRST=1, spi_clk period 8 clk; send ch0=0x01, ch1=0x00, data_ready=1. Expected: data_out[0]=0x01, data_out[1]=0x00, data_valid high exactly 1 cycle, overrun=0.
- Bit order: MSB_FIRST=0, send ch0 serial sequence 1,0,0,0,0,0,0,0 and ch1 sequence 0xA5 pattern. Expected: data_out[0]=0x01 and ch1 word equals the bit-reversed pattern. Also loopback with nspi_tx (same params) for 4 frames 0x01/0x00, 0xFF/0x80, 0x5A/0xA5, 0x00/0xFF; every word matches.
- Backpressure/overrun: data_ready=0, send frames 0x11/0x22 then 0x33/0x44. Expected: overrun=1 for one cycle, data_out=0x33/0x44, data_valid=1. Then raise data_ready; data_valid clears the next cycle.
- Timeout: send 5 bits then stop spi_clk for 70 clk. Expected: busy falls after 64 idle cycles, no data_valid. A following full frame 0xC3/0x3C is received correctly.
- Simultaneous: hold data_valid=1, assert data_ready in the exact cycle the next word loads. Expected: data_valid stays 1, new word presented, overrun=0.
- Reset mid-frame: pull rst low after 3 bits for 2 clk. Expected: all outputs 0 immediately (async). The next full frame 0x7E/0x81 is received intact.
